// File: rtl/riscv_pkg.sv
// Shared RV64 encodings and issue-sequencer state codes, used by
// alu_issue_ctrl, reg_file and the ALU.
package riscv_pkg;

    // Major opcodes handled by the issue controller
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // func3 codes
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_DOUBLE  = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // func7 codes
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned XLEN     = 64;

    // Sequencer states, visible to the ALU on the sup bus
    typedef enum logic [2:0] {
        SUP_IDLE   = 3'b000,
        SUP_DECODE = 3'b001,
        SUP_EXEC   = 3'b010,
        SUP_MEM    = 3'b011,
        SUP_WB     = 3'b100,
        SUP_HALT   = 3'b111
    } sup_e;

    // Instruction class decided in DECODE
    typedef enum logic [1:0] {
        KIND_ALU = 2'b00,
        KIND_LD  = 2'b01,
        KIND_SD  = 2'b10
    } op_kind_e;

    // Sign-extend a 12-bit immediate to XLEN
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32 x 64 integer register file: two combinational read ports, one
// synchronous write port, asynchronous active-low clear, x0 fixed at zero.
module reg_file
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            we_i,
    input  logic [4:0]      wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    // Register storage; writes to x0 are dropped so its entry stays zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wr_addr_i != 5'd0)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read ports; x0 forced to zero independent of storage contents
    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if (rs1_addr_i != 5'd0) rs1_data_o = regs_q[rs1_addr_i];
        if (rs2_addr_i != 5'd0) rs2_data_o = regs_q[rs2_addr_i];
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// RV64 ALU issue controller: accepts one instruction at a time, decodes it,
// presents operands to an external ALU, performs ld/sd memory access and
// writes back to an internal register file.
// Optional build macro ALU_ISSUE_ILLEGAL_TRAP_EN: an illegal instruction
// parks the sequencer in a sticky HALT state until reset.
module alu_issue_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [2:0]  sup,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [63:0] a,
    output logic [63:0] b,
    input  logic [63:0] alu_out,
    output logic [63:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [63:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [63:0] mem_wr_data,
    output logic        done,
    output logic        illegal
);

    sup_e            state_q, state_d;
    logic [31:0]     instr_q;
    logic [6:0]      opcode_q;
    logic [2:0]      func3_q;
    logic [6:0]      func7_q;
    logic [63:0]     a_q, b_q;
    logic [63:0]     wdata_q;
    logic [63:0]     ld_data_q;
    logic [4:0]      rd_q;
    op_kind_e        kind_q;
    logic            illegal_q;

    // Fields of the latched instruction
    logic [6:0]      in_opcode;
    logic [2:0]      in_func3;
    logic [6:0]      in_func7;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic [63:0]     imm_i, imm_s;
    logic [63:0]     rs1_data, rs2_data;

    // Decode results, valid while in DECODE
    logic            dec_illegal;
    op_kind_e        dec_kind;
    logic [63:0]     dec_a, dec_b;

    // Write-back port
    logic            rf_we;
    logic [63:0]     rf_wdata;

    assign in_opcode = instr_q[6:0];
    assign in_rd     = instr_q[11:7];
    assign in_func3  = instr_q[14:12];
    assign in_rs1    = instr_q[19:15];
    assign in_rs2    = instr_q[24:20];
    assign in_func7  = instr_q[31:25];
    assign imm_i     = sext12(instr_q[31:20]);
    assign imm_s     = sext12({instr_q[31:25], instr_q[11:7]});

    reg_file u_rf (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rs1_addr_i (in_rs1),
        .rs2_addr_i (in_rs2),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .we_i       (rf_we),
        .wr_addr_i  (rd_q),
        .wr_data_i  (rf_wdata)
    );

    // Operand selection and legality check for the latched instruction
    always_comb begin
        dec_illegal = 1'b1;
        dec_kind    = KIND_ALU;
        dec_a       = rs1_data;
        dec_b       = '0;
        unique case (in_opcode)
            OPC_OP_IMM: begin
                if (in_func3 == F3_ADD_SUB) begin
                    dec_illegal = 1'b0;
                    dec_b       = imm_i;
                end else if ((in_func3 == F3_SLL) && (instr_q[31:26] == 6'd0)) begin
                    dec_illegal = 1'b0;
                    dec_b       = {58'd0, instr_q[25:20]};
                end
            end
            OPC_OP: begin
                dec_b = rs2_data;
                if (in_func7 == F7_BASE) begin
                    if ((in_func3 == F3_ADD_SUB) || (in_func3 == F3_XOR) ||
                        (in_func3 == F3_OR) || (in_func3 == F3_AND)) begin
                        dec_illegal = 1'b0;
                    end else if (in_func3 == F3_SLL) begin
                        // ALU evaluates b<<a, so the shift amount goes on a
                        dec_illegal = 1'b0;
                        dec_a       = rs2_data;
                        dec_b       = rs1_data;
                    end
                end else if (in_func7 == F7_ALT) begin
                    if (in_func3 == F3_ADD_SUB) begin
                        dec_illegal = 1'b0;
                    end else if (in_func3 == F3_SRL_SRA) begin
                        // ALU evaluates b>>>a, so the shift amount goes on a
                        dec_illegal = 1'b0;
                        dec_a       = rs2_data;
                        dec_b       = rs1_data;
                    end
                end
            end
            OPC_LOAD: begin
                if (in_func3 == F3_DOUBLE) begin
                    dec_illegal = 1'b0;
                    dec_kind    = KIND_LD;
                    dec_b       = imm_i;
                end
            end
            OPC_STORE: begin
                if (in_func3 == F3_DOUBLE) begin
                    dec_illegal = 1'b0;
                    dec_kind    = KIND_SD;
                    dec_b       = imm_s;
                end
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SUP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe outputs
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        case (state_q)
            SUP_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = SUP_DECODE;
            end
            SUP_DECODE: begin
                state_d = dec_illegal ? SUP_WB : SUP_EXEC;
            end
            SUP_EXEC: begin
                state_d = SUP_MEM;
            end
            SUP_MEM: begin
                state_d   = SUP_WB;
                mem_addr  = alu_out;
                mem_rd_en = (kind_q == KIND_LD);
                mem_wr_en = (kind_q == KIND_SD);
            end
            SUP_WB: begin
                done    = 1'b1;
                illegal = illegal_q;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                state_d = illegal_q ? SUP_HALT : SUP_IDLE;
`else
                state_d = SUP_IDLE;
`endif
            end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            SUP_HALT: begin
                state_d = SUP_HALT;
            end
`endif
            default: begin
                state_d = SUP_IDLE;
            end
        endcase
    end

    // Instruction latch, decoded operand registers and load-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            opcode_q  <= '0;
            func3_q   <= '0;
            func7_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
            rd_q      <= '0;
            kind_q    <= KIND_ALU;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                SUP_IDLE: begin
                    if (instr_valid) begin
                        instr_q   <= instr;
                        illegal_q <= 1'b0;
                    end
                end
                SUP_DECODE: begin
                    opcode_q  <= in_opcode;
                    func3_q   <= in_func3;
                    func7_q   <= in_func7;
                    a_q       <= dec_a;
                    b_q       <= dec_b;
                    rd_q      <= in_rd;
                    kind_q    <= dec_kind;
                    illegal_q <= dec_illegal;
                    wdata_q   <= (dec_kind == KIND_SD) ? rs2_data : '0;
                end
                SUP_MEM: begin
                    if (kind_q == KIND_LD) ld_data_q <= mem_rd_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Write-back: ALU result or load data, never for stores or illegal ops
    always_comb begin
        rf_we    = (state_q == SUP_WB) && !illegal_q && (kind_q != KIND_SD);
        rf_wdata = (kind_q == KIND_LD) ? ld_data_q : alu_out;
    end

    assign sup         = state_q;
    assign opcode      = opcode_q;
    assign func3       = func3_q;
    assign func7       = func7_q;
    assign a           = a_q;
    assign b           = b_q;
    assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small ALU and memory model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [2:0]  sup;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [63:0] a, b;
    logic [63:0] alu_out = '0;
    logic [63:0] mem_addr;
    logic        mem_rd_en;
    logic [63:0] mem_rd_data;
    logic        mem_wr_en;
    logic [63:0] mem_wr_data;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem [32] = '{default: '0};

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .sup         (sup),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .a           (a),
        .b           (b),
        .alu_out     (alu_out),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Reference ALU: registers its result at the end of an EXEC cycle
    function automatic logic [63:0] alu_model(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [63:0] x,
                                              input logic [63:0] y);
        logic [63:0] r;
        r = x + y;
        if (op == 7'b0010011 && f3 == 3'b001) r = x << y[5:0];
        if (op == 7'b0110011) begin
            case (f3)
                3'b000:  r = f7[5] ? (x - y) : (x + y);
                3'b001:  r = y << x[5:0];
                3'b100:  r = x ^ y;
                3'b101:  r = $signed(y) >>> x[5:0];
                3'b110:  r = x | y;
                3'b111:  r = x & y;
                default: r = x + y;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (sup == 3'b010) alu_out <= alu_model(opcode, func3, func7, a, b);
    end

    // Memory model: 32 doublewords indexed by address bits [7:3]
    assign mem_rd_data = mem[mem_addr[7:3]];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[7:3]] <= mem_wr_data;
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] xreg(input int idx);
        return dut.u_rf.regs_q[idx];
    endfunction

    // Offer an instruction and complete the handshake edge
    task automatic handshake(input logic [31:0] ins);
        int waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk_eq("ready_before_offer", {63'd0, instr_ready}, 64'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 32'hFFFF_FFFF;
    endtask

    // Follow an accepted instruction to its done pulse; ncyc counts the
    // IDLE cycle that ended with the handshake as cycle 1
    task automatic track(output int ncyc, output logic [63:0] ea, output logic [63:0] eb,
                         output logic [6:0] ef7, output logic ill, output logic saw_rd,
                         output logic saw_wr, output logic [63:0] wa, output logic [63:0] wd);
        logic seen = 1'b0;
        ncyc = 1; ea = '0; eb = '0; ef7 = '0; ill = 1'b0;
        saw_rd = 1'b0; saw_wr = 1'b0; wa = '0; wd = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            ncyc++;
            if (sup == 3'b010) begin
                ea = a; eb = b; ef7 = func7;
            end
            if (mem_rd_en) saw_rd = 1'b1;
            if (mem_wr_en) begin
                saw_wr = 1'b1; wa = mem_addr; wd = mem_wr_data;
            end
            if (done) begin
                seen = 1'b1;
                ill  = illegal;
            end
        end
        if (!seen) ncyc = -1;
        @(posedge clk);
        #1;
    endtask

    int          nc;
    logic [63:0] ea, eb, wa, wd;
    logic [6:0]  ef7;
    logic        ill, srd, swr;

    task automatic run(input logic [31:0] ins);
        handshake(ins);
        track(nc, ea, eb, ef7, ill, srd, swr, wa, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #3;
        chk_eq("rst_sup", {61'd0, sup}, 64'd0);
        chk_eq("rst_ready", {63'd0, instr_ready}, 64'd1);
        chk_eq("rst_done", {62'd0, done, illegal}, 64'd0);
        chk_eq("rst_mem_en", {62'd0, mem_rd_en, mem_wr_en}, 64'd0);
        chk_eq("rst_ab", a | b | mem_addr | mem_wr_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5
        run(32'h0050_0093);
        chk_eq("addi_a", ea, 64'd0);
        chk_eq("addi_b", eb, 64'd5);
        chk_eq("addi_cycles", nc, 64'd5);
        chk_eq("addi_x1", xreg(1), 64'd5);
        chk_eq("addi_nomem", {62'd0, srd, swr}, 64'd0);

        // addi x2,x0,3 ; sub x3,x1,x2 ; sll x4,x1,x2
        run(32'h0030_0113);
        chk_eq("addi_x2", xreg(2), 64'd3);
        run(32'h4020_81B3);
        chk_eq("sub_f7", {57'd0, ef7}, 64'h20);
        chk_eq("sub_x3", xreg(3), 64'd2);
        run(32'h0020_9233);
        chk_eq("sll_a", ea, 64'd3);
        chk_eq("sll_b", eb, 64'd5);
        chk_eq("sll_x4", xreg(4), 64'd40);

        // addi x0,x0,7: discarded write
        run(32'h0070_0013);
        chk_eq("x0_cycles", nc, 64'd5);
        chk_eq("x0_zero", xreg(0), 64'd0);

        // addi x7,x1,-1: sign-extended immediate
        run(32'hFFF0_8393);
        chk_eq("neg_b", eb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk_eq("neg_x7", xreg(7), 64'd4);

        // addi x1,x0,0x100 ; sd x1,8(x1) ; ld x5,8(x1)
        run(32'h1000_0093);
        chk_eq("x1_100", xreg(1), 64'h100);
        run(32'h0010_B423);
        chk_eq("sd_wr", {63'd0, swr}, 64'd1);
        chk_eq("sd_addr", wa, 64'h108);
        chk_eq("sd_data", wd, 64'h100);
        chk_eq("sd_cycles", nc, 64'd5);
        chk_eq("sd_mem", mem[1], 64'h100);
        run(32'h0080_B283);
        chk_eq("ld_rd", {63'd0, srd}, 64'd1);
        chk_eq("ld_nowr", {63'd0, swr}, 64'd0);
        chk_eq("ld_x5", xreg(5), 64'h100);

        // Illegal opcode 1111111
        run(32'h0000_007F);
        chk_eq("ill_flag", {63'd0, ill}, 64'd1);
        chk_eq("ill_cycles", nc, 64'd3);
        chk_eq("ill_nomem", {62'd0, srd, swr}, 64'd0);
        chk_eq("ill_regs", xreg(5), 64'h100);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        repeat (4) @(negedge clk);
        chk_eq("trap_ready", {63'd0, instr_ready}, 64'd0);
        chk_eq("trap_sup", {61'd0, sup}, 64'd7);
        rst_n = 1'b0;
        #1;
        chk_eq("trap_rst_ready", {63'd0, instr_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
`else
        chk_eq("ill_back_idle", {60'd0, instr_ready, sup}, 64'h8);
`endif

        // Reset during MEM of sd x4,16(x1)
        run(32'h1000_0093);
        run(32'h0550_0213);
        chk_eq("x4_55", xreg(4), 64'h55);
        handshake(32'h0040_B823);
        for (int i = 0; i < 6 && sup != 3'b011; i++) @(negedge clk);
        chk_eq("mid_in_mem", {61'd0, sup}, 64'd3);
        chk_eq("mid_wr_en", {63'd0, mem_wr_en}, 64'd1);
        chk_eq("mid_addr", mem_addr, 64'h110);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_wr_fall", {63'd0, mem_wr_en}, 64'd0);
        chk_eq("mid_sup", {61'd0, sup}, 64'd0);
        chk_eq("mid_ready", {63'd0, instr_ready}, 64'd1);
        chk_eq("mid_outs", a | b | mem_addr | mem_wr_data | {57'd0, opcode}, 64'd0);
        chk_eq("mid_regs", xreg(4) | xreg(1), 64'd0);
        @(negedge clk);
        chk_eq("mid_no_store", mem[2], 64'd0);

        // First handshake on first rising edge after reset release
        rst_n       = 1'b1;
        instr       = 32'h0050_0093;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk_eq("post_rst_hs", {61'd0, sup}, 64'd1);
        track(nc, ea, eb, ef7, ill, srd, swr, wa, wd);
        chk_eq("post_rst_cycles", nc, 64'd5);
        chk_eq("post_rst_x1", xreg(1), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have ports: clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: instr_valid in 1 and instr in 32, RV64 instruction offer.
REQ-004 SHALL have ports: instr_ready, output, 1, instruction accepted when instr_valid and instr_ready are both high.
REQ-005 SHALL have ports: sup out 3; opcode out 7; func3 out 3; func7 out 7; a out 64; b out 64, all driving the ALU.
REQ-006 SHALL have ports: alu_out, input, 64, ALU result, registered by the ALU at the end of a sup=010 cycle.
REQ-007 SHALL have ports: mem_addr out 64; mem_rd_en out 1; mem_rd_data in 64; mem_wr_en out 1; mem_wr_data out 64.
REQ-008 SHALL have ports: done out 1 and illegal out 1, completion and decode-fault pulses.

Function
REQ-009 SHALL sequence through states on sup: 000 IDLE, 001 DECODE, 010 EXEC, 011 MEM, 100 WB, then return to IDLE; 101-111 are unreachable and recover to IDLE on the next edge.
REQ-010 SHALL drive instr_ready high only in IDLE; a handshake SHALL latch instr and move to DECODE on the same edge; instr_valid outside IDLE SHALL be ignored.
REQ-011 SHALL in DECODE read rs1/rs2 from an internal 32x64 register file and register opcode, func3, func7, a and b, held stable through EXEC and MEM.
REQ-012 SHALL for I-type (0010011) addi/slli drive a=x[rs1] and b=sign-extended imm[11:0]; slli uses imm[5:0] zero-extended.
REQ-013 SHALL for R-type (0110011) add/sub/xor/or/and drive a=x[rs1] and b=x[rs2]; sll/sra SHALL swap the operands (a=x[rs2], b=x[rs1]) because the ALU computes b<<a and b>>>a.
REQ-014 SHALL for ld (0000011, func3=011) drive a=x[rs1] and b=sign-extended I-imm; for sd (0100011, func3=011) drive b=sign-extended S-imm {imm[11:5],imm[4:0]}.
REQ-015 SHALL in MEM set mem_addr=alu_out; ld SHALL pulse mem_rd_en and register mem_rd_data at the end of MEM; sd SHALL pulse mem_wr_en with mem_wr_data=x[rs2]; all other instructions SHALL leave both enables low.
REQ-016 SHALL in WB write rd with alu_out (ALU ops) or the registered load data (ld); sd writes nothing; writes to x0 SHALL be discarded and x0 SHALL always read 0.
REQ-017 SHALL pulse done for exactly one cycle, in WB; a legal instruction SHALL take exactly 5 cycles from handshake edge to the done cycle inclusive.
REQ-018 SHALL treat any opcode/func3/func7 combination not listed in REQ-012..014 as illegal: jump DECODE->WB, make no register write and no memory access, and pulse illegal together with done.

Reset
REQ-019 SHALL on rst_n low, immediately and independently of clk: sup=000, instr_ready=1, done=0, illegal=0, mem_rd_en=0, mem_wr_en=0, opcode/func3/func7/a/b/mem_addr/mem_wr_data=0, all 32 registers=0.
REQ-020 SHALL abandon an in-flight instruction when reset is asserted mid-operation, with no partial register write or memory strobe afterwards; first handshake SHALL be possible on the first rising edge after rst_n rises.

Configuration
REQ-021 SHALL with ALU_ISSUE_ILLEGAL_TRAP_EN defined: an illegal instruction enters a sticky HALT state after its WB; instr_ready stays 0 until reset; sup holds 111.
REQ-022 SHALL with ALU_ISSUE_ILLEGAL_TRAP_EN undefined: illegal instructions behave as NOPs per REQ-018 and the block returns to IDLE.

Structure
REQ-023 SHALL take opcode constants (0010011, 0110011, 0000011, 0100011), func3/func7 codes and sup state encodings from shared package riscv_pkg, also used by alu.
REQ-024 SHALL place the register file in sub-module reg_file (2 combinational read ports, 1 synchronous write port, async active-low clear, x0 hardwired to 0).

Verification
REQ-025 SHALL cover: reset, then addi x1,x0,5 (0x00500093) -> a=0, b=5 at sup=010; x1=5 at WB; done high on the 5th cycle.
REQ-026 SHALL cover: x1=5, x2=3, then sub x3,x1,x2 then sll x4,x1,x2 -> x3=2; at sll EXEC a=3, b=5; x4=40.
REQ-027 SHALL cover: x1=0x100, then sd x1,8(x1) then ld x5,8(x1) with a memory model -> mem_wr_en pulse at addr 0x108 with data 0x100; x5=0x100.
REQ-028 SHALL cover: addi x0,x0,7 -> no write occurs; x0 reads 0; done pulses.
REQ-029 SHALL cover: opcode 1111111 -> illegal and done pulse together, no memory strobe; with TRAP_EN instr_ready stays 0 until rst_n pulses.
REQ-030 SHALL cover: rst_n low during MEM of an sd -> mem_wr_en falls at once; all outputs take their REQ-019 values; no register changes.
